pc_gen: RTL
===========

# pc_gen

Parametrised stage-1 next-PC generator. It owns the architectural fetch PC register and selects among the sequential increment, stage-2 redirects (branch/jump target from the ALU), and a trap vector. It holds the PC under a pipeline stall and buffers any redirect or trap that arrives while stalled. It drives the instruction-memory address and produces a flush pulse so stage 1 can squash the wrong-path instruction.

## Interface
- `PC_WIDTH`, 32: width of all PC and target buses.
- `RESET_PC`, 32'h0000_2000: PC value loaded on reset.
- `INCR`, 4: sequential increment.
- `ALIGN_BITS`, 2: number of low target bits forced to zero.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC this cycle.
- `redirect_valid`  in  1  stage-2 branch/jump taken.
- `redirect_target`  in  PC_WIDTH  stage-2 ALU_Out target.
- `trap_valid`  in  1  trap request.
- `trap_vector`  in  PC_WIDTH  trap handler address.
- `pc`  out  PC_WIDTH  current fetch PC (registered).
- `pc_plus_incr`  out  PC_WIDTH  `pc + INCR`, combinational, modulo 2^PC_WIDTH.
- `flush`  out  1  registered; high for the cycle in which `pc` first shows a non-sequential value.
- `redirect_pending`  out  1  buffered redirect/trap waiting for stall release.
- `misalign_err`  out  1  registered one-cycle pulse; accepted redirect had nonzero low ALIGN_BITS.

## Operation
- State: `pc` register, pending buffer (`pend_valid`, `pend_is_trap`, `pend_target`), `flush` and `misalign_err` registers.
- Reset (edge with `reset`=1): `pc`=RESET_PC, `pend_valid`=0, `pend_is_trap`=0, `flush`=0, `misalign_err`=0. Reset overrides every other input, including mid-stall and pending state.
- Target masking: redirect and pending targets have their low ALIGN_BITS cleared before loading. `trap_vector` is loaded unmasked.
- Not stalled (`stall`=0), next-PC priority:
  1. `trap_valid`: load `trap_vector`.
  2. `redirect_valid`: load the masked `redirect_target`.
  3. `pend_valid`: load `pend_target`.
  4. Otherwise: load `pc + INCR`, with wrap-around and no carry out.
- When not stalled, the pending buffer always clears.
- `flush`=1 on the next cycle iff case 1, 2 or 3 loaded.
- Stalled (`stall`=1):
  - `pc` holds and `flush`=0.
  - `trap_valid`: buffer `trap_vector`, set `pend_is_trap`=1. This overwrites any buffered redirect.
  - `redirect_valid` with `trap_valid`=0: buffer the masked target, but only if `pend_is_trap`=0. The latest redirect overwrites an older one; a redirect is dropped if a trap is already buffered.
  - Both valid together: the trap is buffered.
- `misalign_err` pulses the cycle after a redirect that is either loaded or buffered and has nonzero low bits. A dropped redirect does not pulse.
- `redirect_pending` = `pend_valid`.

## Timing
- PC update latency: 1 cycle. A redirect presented in cycle N appears on `pc` in cycle N+1, with `flush`=1 in N+1.
- Buffered redirect: loads in the first cycle with `stall`=0. It appears on `pc` one cycle later, with `flush`=1 and `redirect_pending`=0.
- A live redirect/trap in the release cycle beats the buffered one; the buffer is discarded.
- `pc_plus_incr` follows `pc` combinationally in the same cycle.
- No combinational path from any input to `pc`, `flush`, `redirect_pending` or `misalign_err`.

## Test plan
- Reset, then 3 idle cycles → `pc` = 0x2000, 0x2004, 0x2008, 0x200C; `flush`=0.
- At `pc`=0x2008, `redirect_valid`=1, target 0x3003 → next `pc`=0x3000, `flush`=1, `misalign_err`=1 for one cycle, then 0x3004.
- Stall 3 cycles, redirect 0x4000 in stall cycle 1 and 0x5000 in stall cycle 2 → `pc` held, `redirect_pending`=1. Release → `pc`=0x5000 with `flush`=1, `redirect_pending`=0.
- Stall with trap 0x100 then redirect 0x6000 → redirect dropped, no `misalign_err`. Release → `pc`=0x100. Separately, `trap_valid` and `redirect_valid` together unstalled → `pc`=`trap_vector`.
- `PC_WIDTH`=16, `pc`=0xFFFC, idle → `pc`=0x0000. Assert `reset` while stalled with a pending redirect → `pc`=RESET_PC, `redirect_pending`=0, no flush after reset.

Source files
------------

// File: rtl/pc_gen.sv
// Stage-1 next-PC generator: trap > redirect > pending > pc+INCR, 1-cycle update latency.
// Backpressure: stall holds pc and buffers the latest trap/redirect until release.
module pc_gen #(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(32'h0000_2000),
  parameter int                  INCR       = 4,
  parameter int                  ALIGN_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                trap_valid,
  input  logic [PC_WIDTH-1:0] trap_vector,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus_incr,
  output logic                flush,
  output logic                redirect_pending,
  output logic                misalign_err
);

  localparam logic [PC_WIDTH-1:0] LOW_MASK  = (PC_WIDTH'(1) << ALIGN_BITS) - PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] INCR_VAL  = PC_WIDTH'(INCR);

  logic                pend_valid;
  logic                pend_is_trap;
  logic [PC_WIDTH-1:0] pend_target;

  logic [PC_WIDTH-1:0] redirect_masked;
  logic                redirect_misaligned;

  logic [PC_WIDTH-1:0] pc_next;
  logic                flush_next;
  logic                misalign_next;
  logic                pend_valid_next;
  logic                pend_is_trap_next;
  logic [PC_WIDTH-1:0] pend_target_next;

  assign redirect_masked     = redirect_target & ~LOW_MASK;
  assign redirect_misaligned = |(redirect_target & LOW_MASK);
  assign pc_plus_incr        = pc + INCR_VAL;
  assign redirect_pending    = pend_valid;

  always_comb begin
    pc_next           = pc;
    flush_next        = 1'b0;
    misalign_next     = 1'b0;
    pend_valid_next   = pend_valid;
    pend_is_trap_next = pend_is_trap;
    pend_target_next  = pend_target;

    if (!stall) begin
      // The buffer is consumed or discarded on every unstalled cycle.
      pend_valid_next   = 1'b0;
      pend_is_trap_next = 1'b0;
      if (trap_valid) begin
        pc_next    = trap_vector;
        flush_next = 1'b1;
      end else if (redirect_valid) begin
        pc_next       = redirect_masked;
        flush_next    = 1'b1;
        misalign_next = redirect_misaligned;
      end else if (pend_valid) begin
        pc_next    = pend_target;
        flush_next = 1'b1;
      end else begin
        pc_next = pc_plus_incr;
      end
    end else begin
      if (trap_valid) begin
        pend_valid_next   = 1'b1;
        pend_is_trap_next = 1'b1;
        pend_target_next  = trap_vector;
      end else if (redirect_valid && !(pend_valid && pend_is_trap)) begin
        // A buffered trap outranks any later redirect; the redirect is dropped.
        pend_valid_next   = 1'b1;
        pend_is_trap_next = 1'b0;
        pend_target_next  = redirect_masked;
        misalign_next     = redirect_misaligned;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      pend_valid   <= 1'b0;
      pend_is_trap <= 1'b0;
      pend_target  <= '0;
    end else begin
      pc           <= pc_next;
      flush        <= flush_next;
      misalign_err <= misalign_next;
      pend_valid   <= pend_valid_next;
      pend_is_trap <= pend_is_trap_next;
      pend_target  <= pend_target_next;
    end
  end

endmodule
